// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - request/response and RAM-side signal bundle for ram_port_arbiter
interface ram_port_arbiter_if #(
    parameter int WORD_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  f_req_valid;
    logic                  f_req_ready;
    logic [ADDR_WIDTH-1:0] f_addr;
    logic                  f_rsp_valid;
    logic [WORD_WIDTH-1:0] f_rsp_data;
    logic                  f_rsp_ready;

    logic                  d_req_valid;
    logic                  d_req_write;
    logic                  d_req_ready;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [WORD_WIDTH-1:0] d_wdata;
    logic                  d_rsp_valid;
    logic [WORD_WIDTH-1:0] d_rsp_data;
    logic                  d_rsp_ready;

    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [WORD_WIDTH-1:0] ram_wdata;
    logic [WORD_WIDTH-1:0] ram_rdata;

    // Arbiter side: consumes requests and RAM read data, produces responses and RAM controls.
    modport slave (
        input  f_req_valid, f_addr, f_rsp_ready,
        input  d_req_valid, d_req_write, d_addr, d_wdata, d_rsp_ready,
        input  ram_rdata,
        output f_req_ready, f_rsp_valid, f_rsp_data,
        output d_req_ready, d_rsp_valid, d_rsp_data,
        output ram_we, ram_raddr, ram_waddr, ram_wdata
    );

    modport master (
        output f_req_valid, f_addr, f_rsp_ready,
        output d_req_valid, d_req_write, d_addr, d_wdata, d_rsp_ready,
        output ram_rdata,
        input  f_req_ready, f_rsp_valid, f_rsp_data,
        input  d_req_ready, d_rsp_valid, d_rsp_data,
        input  ram_we, ram_raddr, ram_waddr, ram_wdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - fetch/load-store front-end sharing one RAM read port, with write-first forwarding
module ram_port_arbiter #(
    parameter int WORD_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic             gclk,
    input  logic             nreset,
    ram_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } port_state_e;

    port_state_e           f_state_q, f_state_d;
    port_state_e           d_state_q, d_state_d;
    logic [WORD_WIDTH-1:0] f_hold_q, f_hold_d;
    logic [WORD_WIDTH-1:0] d_hold_q, d_hold_d;
    logic                  fwd_q, fwd_d;
    logic [WORD_WIDTH-1:0] fwd_data_q, fwd_data_d;
    logic                  last_grant_d_q, last_grant_d_d;

    logic                  f_elig, d_elig;
    logic                  f_rd_req, d_rd_req;
    logic                  f_grant, d_grant;
    logic                  contend;
    logic                  d_store;
    logic [WORD_WIDTH-1:0] f_rsp_data_c, d_rsp_data_c;

    function automatic port_state_e next_state(port_state_e s, logic rsp_ready, logic accept);
        port_state_e n;
        n = ST_IDLE;
        case (s)
            ST_IDLE: n = accept ? ST_WAIT : ST_IDLE;
            ST_WAIT,
            ST_HOLD: n = rsp_ready ? (accept ? ST_WAIT : ST_IDLE) : ST_HOLD;
            default: n = ST_IDLE;
        endcase
        return n;
    endfunction

    // A port may take a new read when nothing is pending or its pending response drains this cycle.
    assign f_elig   = (f_state_q == ST_IDLE) | bus.f_rsp_ready;
    assign d_elig   = (d_state_q == ST_IDLE) | bus.d_rsp_ready;
    assign f_rd_req = nreset & bus.f_req_valid & f_elig;
    assign d_rd_req = nreset & bus.d_req_valid & ~bus.d_req_write & d_elig;
    assign d_store  = nreset & bus.d_req_valid & bus.d_req_write;
    assign contend  = f_rd_req & d_rd_req;

    // On contention the port that did not win last time is granted.
    assign f_grant  = f_rd_req & (~d_rd_req | last_grant_d_q);
    assign d_grant  = d_rd_req & (~f_rd_req | ~last_grant_d_q);

    assign bus.f_req_ready = f_grant;
    assign bus.d_req_ready = nreset & (bus.d_req_write | d_grant);

    assign bus.ram_we    = d_store;
    assign bus.ram_waddr = d_store ? bus.d_addr  : '0;
    assign bus.ram_wdata = d_store ? bus.d_wdata : '0;
    assign bus.ram_raddr = f_grant ? bus.f_addr : (d_grant ? bus.d_addr : '0);

    always_comb begin
        f_rsp_data_c = '0;
        case (f_state_q)
            ST_WAIT: f_rsp_data_c = fwd_q ? fwd_data_q : bus.ram_rdata;
            ST_HOLD: f_rsp_data_c = f_hold_q;
            default: f_rsp_data_c = '0;
        endcase
    end

    always_comb begin
        d_rsp_data_c = '0;
        case (d_state_q)
            ST_WAIT: d_rsp_data_c = bus.ram_rdata;
            ST_HOLD: d_rsp_data_c = d_hold_q;
            default: d_rsp_data_c = '0;
        endcase
    end

    assign bus.f_rsp_valid = (f_state_q != ST_IDLE);
    assign bus.d_rsp_valid = (d_state_q != ST_IDLE);
    assign bus.f_rsp_data  = f_rsp_data_c;
    assign bus.d_rsp_data  = d_rsp_data_c;

    always_comb begin
        f_state_d      = next_state(f_state_q, bus.f_rsp_ready, f_grant);
        d_state_d      = next_state(d_state_q, bus.d_rsp_ready, d_grant);
        f_hold_d       = f_hold_q;
        d_hold_d       = d_hold_q;
        if ((f_state_q == ST_WAIT) && !bus.f_rsp_ready) begin
            f_hold_d = f_rsp_data_c;
        end
        if ((d_state_q == ST_WAIT) && !bus.d_rsp_ready) begin
            d_hold_d = d_rsp_data_c;
        end
        // The RAM reads old data on a same-address collision, so the store data is kept aside.
        fwd_d          = f_grant & d_store & (bus.f_addr == bus.d_addr);
        fwd_data_d     = fwd_d ? bus.d_wdata : fwd_data_q;
        last_grant_d_d = contend ? d_grant : last_grant_d_q;
    end

    always_ff @(posedge gclk or negedge nreset) begin
        if (!nreset) begin
            f_state_q      <= ST_IDLE;
            d_state_q      <= ST_IDLE;
            f_hold_q       <= '0;
            d_hold_q       <= '0;
            fwd_q          <= 1'b0;
            fwd_data_q     <= '0;
            last_grant_d_q <= 1'b0;
        end else begin
            f_state_q      <= f_state_d;
            d_state_q      <= d_state_d;
            f_hold_q       <= f_hold_d;
            d_hold_q       <= d_hold_d;
            fwd_q          <= fwd_d;
            fwd_data_q     <= fwd_data_d;
            last_grant_d_q <= last_grant_d_d;
        end
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Request front-end that sits directly upstream of the core's synchronous RAM. The RAM has one read port, one write port, and 1-cycle registered read data.
- Merges two requesters onto that RAM:
  - F: instruction fetch, read-only.
  - D: load/store.
- Arbitrates the single read slot between F and D.
- Aligns the RAM's 1-cycle read latency into valid/ready responses, with a holding register per port.
- Forwards write data when a read and a write hit the same address on the same edge.

Parameters:
- WORD_WIDTH, 8, data word width.
- ADDR_WIDTH, 8, address width.

Ports:
- gclk  in  1  system clock; all state updates on rising edge.
- nreset  in  1  asynchronous active-low reset.
- f_req_valid  in  1  fetch read request.
- f_req_ready  out  1  fetch request accepted this cycle.
- f_addr  in  ADDR_WIDTH  fetch address.
- f_rsp_valid  out  1  fetch read data valid.
- f_rsp_data  out  WORD_WIDTH  fetch read data.
- f_rsp_ready  in  1  fetch consumer accepts response.
- d_req_valid  in  1  load/store request.
- d_req_write  in  1  1 = store, 0 = load.
- d_req_ready  out  1  D request accepted this cycle.
- d_addr  in  ADDR_WIDTH  load/store address.
- d_wdata  in  WORD_WIDTH  store data.
- d_rsp_valid  out  1  load data valid.
- d_rsp_data  out  WORD_WIDTH  load data.
- d_rsp_ready  in  1  load consumer accepts response.
- ram_we  out  1  to RAM WriteEnable.
- ram_raddr  out  ADDR_WIDTH  to RAM ReadAddr.
- ram_waddr  out  ADDR_WIDTH  to RAM WriteAddr.
- ram_wdata  out  WORD_WIDTH  to RAM WriteData.
- ram_rdata  in  WORD_WIDTH  from RAM ReadData; valid the cycle after the address is presented.

Behaviour:
- Clock and reset: one clock, gclk; reset nreset is asynchronous, active-low.
- Reset values:
  - Both port states IDLE.
  - f_rsp_valid = d_rsp_valid = 0.
  - Response data = 0 and hold registers = 0.
  - last_grant = F, so D wins the first contention.
  - While nreset is low: ram_we = 0, all req_ready = 0.
- Reset mid-operation discards in-flight reads; no response is produced for them.
- Per-port read state machine (F and D each):
  - IDLE: no read in flight.
  - WAIT: read issued last edge; this cycle rsp_valid = 1 and rsp_data = forwarded ? fwd_data : ram_rdata (combinational).
    - If rsp_ready: go to IDLE, or stay WAIT if a new read is accepted this cycle.
    - Else: capture the data into the hold register and go to HOLD.
  - HOLD: rsp_valid = 1, rsp_data = hold register.
    - On rsp_ready: go to IDLE, or WAIT if a new read is accepted this cycle.
- Read issue eligibility (per port): state is IDLE, or (state is WAIT/HOLD and rsp_ready = 1). This gives a sustained read throughput of 1 per cycle.
- Read slot arbitration:
  - Only one read is issued per cycle.
  - If one eligible port requests a read, it is granted.
  - If both request, the port other than last_grant wins, and last_grant updates to the winner.
  - last_grant is unchanged when there is no contention.
  - Request readiness:
    - f_req_ready = eligible AND granted.
    - For a load, d_req_ready = eligible AND granted.
  - ram_raddr = granted address; 0 when no read is granted.
- Stores:
  - D store is always accepted: d_req_ready = 1 when d_req_write = 1, regardless of D read state.
  - ram_we = d_req_valid & d_req_write, with ram_waddr = d_addr and ram_wdata = d_wdata (combinational).
  - With no store: ram_waddr = 0 and ram_wdata = 0.
  - A store never produces a response and never consumes the read slot.
  - A store therefore proceeds in the same cycle as a granted F read.
- Write-first forwarding:
  - Case: an F read is accepted in the same cycle as a D store, and f_addr == d_addr.
  - The RAM returns old data in that case, so the block latches fwd flag = 1 and fwd_data = d_wdata at that edge.
  - The F response in the next WAIT cycle returns fwd_data.
  - The fwd flag clears when the WAIT cycle ends.
- Ordering:
  - Responses per port are returned in issue order, at most one outstanding.
  - A D load accepted the cycle after a store to the same address returns the new data: the RAM has already committed the write.
- No combinational path from rsp_ready to rsp_valid or rsp_data.
- Paths from rsp_ready to req_ready are permitted.

Test Plan:
- Reset: assert nreset low mid-read with f in WAIT → f_rsp_valid = 0 immediately; after release, the first contention grants D.
- Single fetch: preload RAM[0x10] = 0xA5; f read 0x10 at cycle 0 → f_rsp_valid = 1, f_rsp_data = 0xA5 at cycle 1; back-to-back fetches 0x10, 0x11 give responses in cycles 1 and 2.
- Contention: F and D both read every cycle with both rsp_ready = 1 → grants alternate D, F, D, F; each port gets exactly 1 read per 2 cycles.
- Backpressure: f_rsp_ready = 0 for 3 cycles after a read of 0x20 (data 0x3C) → f_rsp_data held at 0x3C, f_req_ready = 0, D reads still granted; f_rsp_ready = 1 → response drains and a new F read is accepted in the same cycle.
- Forwarding: RAM[0x40] = 0x11; same cycle, F reads 0x40 and D stores 0x40 = 0x99 → F response 0x99, RAM[0x40] = 0x99 afterward. With different addresses, the F response is 0x11.
- Store/load: D stores 0x05 = 0x7E, then loads 0x05 the next cycle → d_rsp_data = 0x7E; d_rsp_valid never asserts for the store.
